// File: rtl/shift_normalizer.sv
// +--------------------------------------------------------------------------+
// | Module      : shift_normalizer                                           |
// | Description : Multi-cycle normalizer (inverse of the barrel shifter).    |
// |               Shifts the accepted operand left one bit per cycle until   |
// |               its MSB is set, returning the normalized value, the number |
// |               of shifts applied and an all-zero flag.                    |
// |               Optional macro SIGNED_NORM_EN adds a signed_mode input     |
// |               that counts redundant sign bits instead of leading zeros.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module shift_normalizer #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
`ifdef SIGNED_NORM_EN
  input  logic             signed_mode,
`endif
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [CW-1:0]    count,
  output logic             zero
);

  localparam logic [CW-1:0] C_CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] C_CNT_SMAX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             zin_q,   zin_d;    // operand-was-zero flag, published at DONE entry
  logic [WIDTH-1:0] out_q,   out_d;
  logic [CW-1:0]    count_q, count_d;
  logic             zero_q,  zero_d;

  // Signed-mode selection: live input at accept time, and the captured mode
  // that steers termination while shifting.
  logic             w_start_sgn;
  logic             w_sgn_mode;
  logic             w_sgn_stop;

`ifdef SIGNED_NORM_EN
  logic             sgn_q, sgn_d;

  assign w_start_sgn = signed_mode;
  assign w_sgn_mode  = sgn_q;
  // Stop once the top two bits differ, or when every bit below the MSB was
  // a redundant sign bit (covers 0 and all-ones).
  assign w_sgn_stop  = (acc_q[WIDTH-1] != acc_q[WIDTH-2]) || (cnt_q == C_CNT_SMAX);

  // Captured signed-mode register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sgn_q <= 1'b0;
    end else begin
      sgn_q <= sgn_d;
    end
  end
`else
  logic             sgn_d;

  assign w_start_sgn = 1'b0;
  assign w_sgn_mode  = 1'b0;
  assign w_sgn_stop  = 1'b0;
`endif

  // State and datapath registers; clear abandons any operation in flight
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      zin_q   <= 1'b0;
      out_q   <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      zin_q   <= zin_d;
      out_q   <= out_d;
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state and datapath control; results are only published on DONE entry
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    zin_d   = zin_q;
    out_d   = out_q;
    count_d = count_q;
    zero_d  = zero_q;
`ifdef SIGNED_NORM_EN
    sgn_d   = sgn_q;
`else
    sgn_d   = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = in;
          cnt_d   = '0;
          zin_d   = (in == '0);
          sgn_d   = w_start_sgn;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (w_sgn_mode) begin
          if (w_sgn_stop) begin
            state_d = S_DONE;
          end else begin
            acc_d = {acc_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + C_CNT_ONE;
          end
        end else if (acc_q == '0) begin
          // Nothing to find: report a full-width count immediately.
          cnt_d   = C_CNT_FULL;
          state_d = S_DONE;
        end else if (acc_q[WIDTH-1]) begin
          state_d = S_DONE;
        end else begin
          acc_d = {acc_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + C_CNT_ONE;
        end

        if (state_d == S_DONE) begin
          out_d   = acc_q;
          count_d = cnt_d;
          zero_d  = zin_q;
        end
      end

      S_DONE: begin
        // Any start seen here is dropped, not queued.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy  = (state_q == S_SHIFT);
  assign done  = (state_q == S_DONE);
  assign out   = out_q;
  assign count = count_q;
  assign zero  = zero_q;

endmodule

`default_nettype wire
